uart_rx: RTL and testbench

// - Serial receiver for the SoC UART peripheral (BAUDS-N-8-1). Pairs with the SoC transmitter.
// - Deserialises rx_i into bytes and holds one byte for the bus Data Register at 0x00002000.
// - Drives Status Register bit 1 (valid). Also reports framing and overrun errors.

---
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: two-flop synchroniser, centre-sampling FSM,
// one-byte holding register with sticky framing and overrun flags.
module uart_rx #(
    parameter int FREQ_MHZ = 12,
    parameter int BAUDS    = 115200
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       rx_i,
    input  logic       rd_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int DIV = FREQ_MHZ * 1000000 / BAUDS;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_rx_s;
    logic          r_prime;
    logic          r_high_seen;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_ovr;

    logic w_half;
    logic w_full;

    assign w_half = (r_cnt == HALF_M1);
    assign w_full = (r_cnt == FULL_M1);

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            r_state     <= IDLE;
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_prime     <= 1'b0;
            r_high_seen <= 1'b0;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shreg     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_sync1 <= rx_i;
            r_rx_s  <= r_sync1;
            r_prime <= 1'b1;
            if (rd_i) begin
                r_valid <= 1'b0;
                r_ferr  <= 1'b0;
                r_ovr   <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    // The preset synchroniser value is not trusted as a real idle level
                    if (r_prime && r_sync1 && r_rx_s) begin
                        r_high_seen <= 1'b1;
                    end else if (r_high_seen && !r_rx_s) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_half) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (w_full) begin
                        r_cnt   <= '0;
                        r_shreg <= {r_rx_s, r_shreg[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (w_full) begin
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                        r_data      <= r_shreg;
                        r_valid     <= 1'b1;
                        r_high_seen <= r_rx_s;
                        // A read in the commit cycle only drops the old byte's flags
                        if (rd_i) begin
                            r_ferr <= ~r_rx_s;
                            r_ovr  <= 1'b0;
                        end else begin
                            r_ferr <= r_ferr | ~r_rx_s;
                            r_ovr  <= r_ovr | r_valid;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 12 MHz / 115200 baud (104 clks per bit).
// Each scenario task drives the line and checks outputs against hand values.
module tb_uart_rx;

    localparam int DIV = 104;

    logic       clk;
    logic       reset_i;
    logic       rx_i;
    logic       rd_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;

    int checks;
    int failures;
    int cyc;
    int start_cyc;
    int rise_cyc;
    logic prev_v;

    uart_rx #(.FREQ_MHZ(12), .BAUDS(115200)) dut (
        .clk        (clk),
        .reset_i    (reset_i),
        .rx_i       (rx_i),
        .rd_i       (rd_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        prev_v   = 1'b0;
        rise_cyc = -1;
    end
    always @(negedge clk) begin
        if (valid_o === 1'b1 && prev_v !== 1'b1) rise_cyc = cyc;
        prev_v = valid_o;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Commit lands 991 clks after the start edge; rd_at_commit hits that edge
    task automatic send_byte(input logic [7:0] b, input logic stop,
                             input bit rd_at_commit);
        start_cyc = cyc;
        rx_i = 1'b0;
        wait_clks(DIV);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_clks(DIV);
        end
        rx_i = stop;
        if (rd_at_commit) begin
            wait_clks(54);
            rd_i = 1'b1;
            wait_clks(1);
            rd_i = 1'b0;
            wait_clks(DIV - 55);
        end else begin
            wait_clks(DIV);
        end
    endtask

    task automatic pulse_rd();
        rd_i = 1'b1;
        wait_clks(1);
        rd_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        rx_i    = 1'b1;
        rd_i    = 1'b0;
        wait_clks(3);
        reset_i = 1'b1;
        wait_clks(1);
        checks++;
        if (data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", data_o);
        end
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", valid_o);
        end
        checks++;
        if (frame_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ferr got=%b exp=0", frame_err_o);
        end
        checks++;
        if (overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovr got=%b exp=0", overrun_o);
        end
        wait_clks(20);
    endtask

    task automatic test_single();
        rise_cyc = -1;
        send_byte(8'hA5, 1'b1, 1'b0);
        checks++;
        if (rise_cyc - start_cyc < 989 || rise_cyc - start_cyc > 993) begin
            failures++;
            $display("FAIL single_latency got=%0d exp=991+-2",
                     rise_cyc - start_cyc);
        end
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'hA5) begin
            failures++;
            $display("FAIL single_byte got=%b/%h exp=1/a5", valid_o, data_o);
        end
        checks++;
        if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL single_flags got=%b%b exp=00",
                     frame_err_o, overrun_o);
        end
        pulse_rd();
        checks++;
        if (valid_o !== 1'b0 || data_o !== 8'hA5) begin
            failures++;
            $display("FAIL single_rd got=%b/%h exp=0/a5", valid_o, data_o);
        end
        wait_clks(20);
    endtask

    task automatic test_back_to_back();
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        checks++;
        if (data_o !== 8'hFF || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_byte got=%h/%b exp=ff/1", data_o, valid_o);
        end
        checks++;
        if (overrun_o !== 1'b1 || frame_err_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_flags got=ovr%b ferr%b exp=ovr1 ferr0",
                     overrun_o, frame_err_o);
        end
        pulse_rd();
        checks++;
        if (overrun_o !== 1'b0 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_rd got=ovr%b v%b exp=ovr0 v0",
                     overrun_o, valid_o);
        end
        wait_clks(20);
    endtask

    task automatic test_glitch();
        rx_i = 1'b0;
        wait_clks(20);
        rx_i = 1'b1;
        wait_clks(200);
        checks++;
        if (valid_o !== 1'b0 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL glitch_idle got=v%b f%b o%b exp=000",
                     valid_o, frame_err_o, overrun_o);
        end
        send_byte(8'h3C, 1'b1, 1'b0);
        checks++;
        if (data_o !== 8'h3C || valid_o !== 1'b1 ||
            frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL glitch_next got=%h v%b f%b o%b exp=3c v1 f0 o0",
                     data_o, valid_o, frame_err_o, overrun_o);
        end
        pulse_rd();
        wait_clks(20);
    endtask

    task automatic test_frame_err();
        send_byte(8'h55, 1'b0, 1'b0);
        rx_i = 1'b1;
        wait_clks(50);
        checks++;
        if (data_o !== 8'h55 || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL ferr_byte got=%h/%b exp=55/1", data_o, valid_o);
        end
        checks++;
        if (frame_err_o !== 1'b1) begin
            failures++;
            $display("FAIL ferr_flag got=%b exp=1", frame_err_o);
        end
        pulse_rd();
        checks++;
        if (valid_o !== 1'b0 || frame_err_o !== 1'b0) begin
            failures++;
            $display("FAIL ferr_rd got=v%b f%b exp=v0 f0",
                     valid_o, frame_err_o);
        end
        wait_clks(20);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h81;
        rx_i = 1'b0;
        wait_clks(DIV);
        for (int i = 0; i < 4; i++) begin
            rx_i = b[i];
            wait_clks(DIV);
        end
        rx_i = b[4];
        wait_clks(50);
        reset_i = 1'b0;
        wait_clks(3);
        reset_i = 1'b1;
        wait_clks(DIV - 53);
        for (int i = 5; i < 8; i++) begin
            rx_i = b[i];
            wait_clks(DIV);
        end
        rx_i = 1'b1;
        wait_clks(DIV + 300);
        checks++;
        if (valid_o !== 1'b0 || data_o !== 8'h00) begin
            failures++;
            $display("FAIL mid_partial got=%b/%h exp=0/00", valid_o, data_o);
        end
        send_byte(8'h42, 1'b1, 1'b0);
        checks++;
        if (data_o !== 8'h42 || valid_o !== 1'b1 ||
            frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_byte got=%h v%b f%b o%b exp=42 v1 f0 o0",
                     data_o, valid_o, frame_err_o, overrun_o);
        end
        send_byte(8'h99, 1'b1, 1'b1);
        checks++;
        if (data_o !== 8'h99 || valid_o !== 1'b1) begin
            failures++;
            $display("FAIL rdcommit_byte got=%h/%b exp=99/1", data_o, valid_o);
        end
        checks++;
        if (overrun_o !== 1'b0 || frame_err_o !== 1'b0) begin
            failures++;
            $display("FAIL rdcommit_flags got=o%b f%b exp=o0 f0",
                     overrun_o, frame_err_o);
        end
        wait_clks(20);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_i  = 1'b0;
        rx_i     = 1'b1;
        rd_i     = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
